captura_de_numero: RTL

- Downstream consumer of the keypad reading stage.
- Takes each latched key (one-hot column/row plus valid flag), acknowledges it and decodes it against the 4x4 keypad map.
- Digits accumulate into a decimal operand, held in both binary and BCD.
- '*' clears the operand, '#' commits it to the next stage, A-D are forwarded as operator codes.

---
 rtl/captura_de_numero_if.sv | 34 +++
 rtl/captura_de_numero.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/captura_de_numero_if.sv
// Key/operand bus between the keypad reading stage, the operand capture
// block and the operand consumer.
interface captura_de_numero_if #(
  parameter int WIDTH  = 4,
  parameter int DIGITS = 4,
  parameter int BIN_W  = 14
) ();
  logic [WIDTH-1:0]             pressed_col_in;
  logic [WIDTH-1:0]             pressed_row_in;
  logic                         pressed_valid_in;
  logic                         ack_read;
  logic [BIN_W-1:0]             number_out;
  logic [4*DIGITS-1:0]          bcd_out;
  logic [$clog2(DIGITS+1)-1:0]  digit_count;
  logic                         number_valid;
  logic                         number_ack;
  logic [1:0]                   op_out;
  logic                         op_valid;
  logic                         key_error;

  // Environment side: reading stage plus operand consumer.
  modport master (
    output pressed_col_in, pressed_row_in, pressed_valid_in, number_ack,
    input  ack_read, number_out, bcd_out, digit_count, number_valid,
    input  op_out, op_valid, key_error
  );

  // Capture block side.
  modport slave (
    input  pressed_col_in, pressed_row_in, pressed_valid_in, number_ack,
    output ack_read, number_out, bcd_out, digit_count, number_valid,
    output op_out, op_valid, key_error
  );
endinterface

// File: rtl/captura_de_numero.sv
// Operand capture: acknowledges latched keypad keys, decodes them against
// the 4x4 map and builds a decimal operand (binary + BCD). '*' clears,
// '#' commits, A-D are forwarded as operator codes. DIGITS must be >= 2.
module captura_de_numero #(
  parameter int WIDTH  = 4,
  parameter int DIGITS = 4,
  parameter int BIN_W  = 14
) (
  input  logic                 clk,
  input  logic                 rst,
  captura_de_numero_if.slave   bus
);
  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(DIGITS + 1);

  // Decoded key codes: 0-9 digits, then '*', '#', and A-D as 12-15.
  localparam logic [3:0] KEY_STAR = 4'd10;
  localparam logic [3:0] KEY_HASH = 4'd11;

  typedef enum logic [1:0] {IDLE, ACK, WAIT_CLR} state_t;

  state_t             state, state_next;
  logic [BIN_W-1:0]   number_q, number_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               nvalid_q, nvalid_d;
  logic [1:0]         op_q, op_d;
  logic               opv_q, opv_d;
  logic               err_q, err_d;
  logic [3:0]         key_code;
  logic               well_formed;
  logic               key_take;

  function automatic logic is_onehot(input logic [WIDTH-1:0] v);
    return (v != '0) && ((v & (v - WIDTH'(1))) == '0);
  endfunction

  function automatic logic [1:0] onehot_index(input logic [WIDTH-1:0] v);
    logic [1:0] idx;
    idx = '0;
    for (int i = 0; i < WIDTH; i++)
      if (v[i]) idx = i[1:0];
    return idx;
  endfunction

  function automatic logic [3:0] decode_key(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] r4, c4;
    r4 = {2'b00, row};
    c4 = {2'b00, col};
    if (col == 2'd3)      return {2'b11, row};
    else if (row == 2'd3) begin
      case (col)
        2'd0:    return KEY_STAR;
        2'd1:    return 4'd0;
        default: return KEY_HASH;
      endcase
    end
    else                  return r4 * 4'd3 + c4 + 4'd1;
  endfunction

  assign well_formed = is_onehot(bus.pressed_row_in) && is_onehot(bus.pressed_col_in);
  assign key_code    = decode_key(onehot_index(bus.pressed_row_in),
                                  onehot_index(bus.pressed_col_in));
  assign key_take    = (state == IDLE) && bus.pressed_valid_in;

  // Handshake state register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next state: one decode per latched key, then wait for the latch to clear.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:     if (bus.pressed_valid_in) state_next = ACK;
      ACK:      state_next = WAIT_CLR;
      WAIT_CLR: if (!bus.pressed_valid_in) state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  // Operand update: consumer ack clears first, then the key acts on the result.
  always_comb begin
    number_d = number_q;
    bcd_d    = bcd_q;
    count_d  = count_q;
    nvalid_d = nvalid_q;
    op_d     = op_q;
    opv_d    = 1'b0;
    err_d    = 1'b0;
    if (nvalid_q && bus.number_ack) begin
      number_d = '0;
      bcd_d    = '0;
      count_d  = '0;
      nvalid_d = 1'b0;
    end
    if (key_take) begin
      if (!well_formed) begin
        err_d = 1'b1;
      end else if (key_code <= 4'd9) begin
        if ((count_d < CNT_W'(DIGITS)) && !nvalid_d) begin
          number_d = number_d * BIN_W'(10) + BIN_W'(key_code);
          bcd_d    = {bcd_d[BCD_W-5:0], key_code};
          count_d  = count_d + CNT_W'(1);
        end else begin
          err_d = 1'b1;
        end
      end else if (key_code == KEY_STAR) begin
        number_d = '0;
        bcd_d    = '0;
        count_d  = '0;
        nvalid_d = 1'b0;
      end else if (key_code == KEY_HASH) begin
        if ((count_d != '0) && !nvalid_d) nvalid_d = 1'b1;
      end else begin
        op_d  = key_code[1:0];
        opv_d = 1'b1;
      end
    end
  end

  // Operand and pulse output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      number_q <= '0;
      bcd_q    <= '0;
      count_q  <= '0;
      nvalid_q <= 1'b0;
      op_q     <= '0;
      opv_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      number_q <= number_d;
      bcd_q    <= bcd_d;
      count_q  <= count_d;
      nvalid_q <= nvalid_d;
      op_q     <= op_d;
      opv_q    <= opv_d;
      err_q    <= err_d;
    end
  end

  assign bus.ack_read     = (state == ACK);
  assign bus.number_out   = number_q;
  assign bus.bcd_out      = bcd_q;
  assign bus.digit_count  = count_q;
  assign bus.number_valid = nvalid_q;
  assign bus.op_out       = op_q;
  assign bus.op_valid     = opv_q;
  assign bus.key_error    = err_q;
endmodule
